// File: rtl/morse_link_pkg.sv
// Shared definitions for the serial link transmitter and its companion
// 8-bit receive shift register: FSM states and receiver select encodings.
package morse_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    DATA  = 2'b10,
    DONE  = 2'b11
  } tx_state_e;

  localparam logic [1:0] SEL_CLEAR = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b01;
  localparam logic [1:0] SEL_SHR   = 2'b10;
  localparam logic [1:0] SEL_SHL   = 2'b11;

endpackage

// File: rtl/bit_period_counter.sv
// Modulo-C cycle counter that times one serial bit period.
// 'last' flags the terminal count, i.e. the final cycle of the period.
module bit_period_counter #(
  parameter int unsigned C = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic last
);

  localparam int unsigned W = (C > 1) ? $clog2(C) : 1;
  localparam logic [W-1:0] TERMINAL = W'(C - 1);

  logic [W-1:0] r_cnt;

  // Count 0..C-1 while enabled, wrap on the terminal count, clear on demand.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == TERMINAL) r_cnt <= '0;
      else                   r_cnt <= r_cnt + W'(1);
    end
  end

  assign last = (r_cnt == TERMINAL);

endmodule

// File: rtl/serial_link_tx.sv
// Serial link transmitter: accepts a byte on a valid/ready handshake, sends it
// LSB-first with CLKS_PER_BIT cycles per bit, and drives the receiver's select
// lines (clear before the frame, shift strobe at the end of each bit period).
module serial_link_tx
  import morse_link_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              serial_output,
  output logic [1:0]        rx_select,
  output logic              busy,
  output logic              done,
  output logic              parity_out
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_parity;
  logic              w_in_data;
  logic              w_period_last;

  assign w_in_data = (r_state == DATA);

  // Period counter runs only in DATA and sits at zero everywhere else, so
  // every frame starts its first bit period from a clean count.
  bit_period_counter #(
    .C (CLKS_PER_BIT)
  ) u_period (
    .CLK  (CLK),
    .RST  (RST),
    .en   (w_in_data),
    .clr  (!w_in_data),
    .last (w_period_last)
  );

  // Frame sequencing: latch byte and parity on acceptance, shift once per
  // bit period, and leave DATA only after the final bit period completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_shift  <= data_in;
            r_parity <= ^data_in;
            r_state  <= CLEAR;
          end
        end
        CLEAR: begin
          r_bit_cnt <= '0;
          r_state   <= DATA;
        end
        DATA: begin
          if (w_period_last) begin
            r_shift <= r_shift >> 1;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state only; nothing here sees data_in.
  // NOTE: every output gets a default before the case so no path through the
  // block leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    load_ready    = 1'b0;
    serial_output = 1'b0;
    rx_select     = SEL_HOLD;
    busy          = 1'b1;
    done          = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
      end
      CLEAR: rx_select = SEL_CLEAR;
      DATA: begin
        serial_output = r_shift[0];
        if (w_period_last) rx_select = SEL_SHR;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign parity_out = r_parity;

endmodule

// File: tb/tb_serial_link_tx.sv
// Self-checking bench for serial_link_tx: one instance at 4 clocks per bit,
// one at 1 clock per bit. Expected per-cycle outputs come from a frame-timing
// model (cycle index arithmetic); a model receiver reassembles each byte.
module tb_serial_link_tx;

  logic       CLK;
  logic       rst4, rst1;
  logic [7:0] din4, din1;
  logic       lv4, lv1;
  logic       lr4, ser4, busy4, done4, par4;
  logic       lr1, ser1, busy1, done1, par1;
  logic [1:0] sel4, sel1;

  int n_vec = 0;
  int n_err = 0;
  logic exp_par [2];

  serial_link_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RST(rst4), .data_in(din4), .load_valid(lv4),
    .load_ready(lr4), .serial_output(ser4), .rx_select(sel4),
    .busy(busy4), .done(done4), .parity_out(par4)
  );

  serial_link_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RST(rst1), .data_in(din1), .load_valid(lv1),
    .load_ready(lr1), .serial_output(ser1), .rx_select(sel1),
    .busy(busy1), .done(done1), .parity_out(par1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Output vector: {load_ready, busy, done, rx_select[1:0], serial_output, parity_out}
  function automatic logic [6:0] obs(input int u);
    if (u == 0) return {lr4, busy4, done4, sel4, ser4, par4};
    else        return {lr1, busy1, done1, sel1, ser1, par1};
  endfunction

  // Expected outputs in cycle n after the acceptance edge (n=1 is the first).
  function automatic logic [6:0] exp_vec(input int n, input int c,
                                         input logic [7:0] d, input logic p);
    int k;
    if (n == 1) return {1'b0, 1'b1, 1'b0, 2'b00, 1'b0, p};
    if (n <= 1 + 8 * c) begin
      k = n - 2;
      return {1'b0, 1'b1, 1'b0, ((k % c) == c - 1) ? 2'b10 : 2'b01, d[k / c], p};
    end
    if (n == 2 + 8 * c) return {1'b0, 1'b1, 1'b1, 2'b01, 1'b0, p};
    return {1'b1, 1'b0, 1'b0, 2'b01, 1'b0, p};
  endfunction

  function automatic logic [6:0] idle_vec(input logic p);
    return {1'b1, 1'b0, 1'b0, 2'b01, 1'b0, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input int u, input logic v, input logic [7:0] d);
    if (u == 0) begin lv4 = v; din4 = d; end
    else        begin lv1 = v; din1 = d; end
  endtask

  // Sends one byte starting from an IDLE cycle and ends in the IDLE cycle after
  // DONE. hold_next keeps load_valid high with next_d for the whole frame.
  // abort_at > 0 pulses reset in that cycle and returns right after.
  task automatic run_frame(input int u, input logic [7:0] d, input bit hold_next,
                           input logic [7:0] next_d, input int abort_at);
    int c;
    logic [7:0] rx;
    logic [6:0] o;
    string tag;
    c = (u == 0) ? 4 : 1;
    set_in(u, 1'b1, d);
    tick();
    exp_par[u] = ^d;
    if (hold_next) set_in(u, 1'b1, next_d);
    else           set_in(u, 1'b0, 8'($urandom));
    rx = 8'($urandom);
    for (int n = 1; n <= 2 + 8 * c; n++) begin
      o = obs(u);
      tag = $sformatf("u%0d_d%02h_cyc%0d", u, d, n);
      check(tag, 32'(o), 32'(exp_vec(n, c, d, exp_par[u])));
      case (o[3:2])
        2'b00:   rx = 8'h00;
        2'b10:   rx = {o[1], rx[7:1]};
        default: ;
      endcase
      if (n == abort_at) begin
        #2;
        if (u == 0) rst4 = 1'b1; else rst1 = 1'b1;
        #1;
        exp_par[u] = 1'b0;
        check($sformatf("u%0d_abort_reset", u), 32'(obs(u)), 32'(idle_vec(1'b0)));
        if (u == 0) rst4 = 1'b0; else rst1 = 1'b0;
        set_in(u, 1'b0, 8'h00);
        return;
      end
      tick();
    end
    check($sformatf("u%0d_d%02h_idle_after", u, d), 32'(obs(u)),
          32'(idle_vec(exp_par[u])));
    check($sformatf("u%0d_d%02h_rx_byte", u, d), 32'(rx), 32'(d));
  endtask

  initial begin
    logic [7:0] rd;
    rst4 = 1'b1; rst1 = 1'b1;
    lv4 = 1'b0;  lv1 = 1'b0;
    din4 = 8'h00; din1 = 8'h00;
    exp_par[0] = 1'b0; exp_par[1] = 1'b0;
    #2;
    check("reset_u4", 32'(obs(0)), 32'(idle_vec(1'b0)));
    check("reset_u1", 32'(obs(1)), 32'(idle_vec(1'b0)));
    tick();
    rst4 = 1'b0; rst1 = 1'b0;
    tick();

    // load_valid low: stays idle regardless of data_in.
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1'b0, 8'($urandom));
      tick();
      check($sformatf("idle_hold_%0d", i), 32'(obs(0)), 32'(idle_vec(1'b0)));
    end

    // Directed frames at 4 clocks per bit.
    run_frame(0, 8'hA5, 1'b0, 8'h00, 0);
    check("parity_A5", 32'(par4), 32'(1'b0));
    run_frame(0, 8'h07, 1'b0, 8'h00, 0);
    check("parity_07", 32'(par4), 32'(1'b1));

    // Second byte held valid during a frame is taken only once back in IDLE.
    run_frame(0, 8'h96, 1'b1, 8'hFF, 0);
    run_frame(0, 8'hFF, 1'b0, 8'h00, 0);

    // Reset during cycle 12 of a frame, then a clean frame.
    run_frame(0, 8'hC3, 1'b0, 8'h00, 12);
    tick();
    check("post_abort_idle", 32'(obs(0)), 32'(idle_vec(1'b0)));
    run_frame(0, 8'h3C, 1'b0, 8'h00, 0);

    // Randomized frames at 4 clocks per bit.
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom);
      run_frame(0, rd, 1'b0, 8'h00, 0);
    end

    // One clock per bit: back-to-back bytes, then randomized chained bytes.
    run_frame(1, 8'h01, 1'b1, 8'h80, 0);
    run_frame(1, 8'h80, 1'b0, 8'h00, 0);
    rd = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] nd;
      nd = 8'($urandom);
      run_frame(1, rd, (i < 3), nd, 0);
      rd = nd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
